seg7_msg_sequencer: RTL and testbench

//  Stores a short message of character codes and plays it on the single 7-segment display.

---
 rtl/seg7_msg_sequencer_if.sv | 28 ++
 rtl/seg7_msg_sequencer.sv | 125 ++++++++++++
 tb/tb_seg7_msg_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_msg_sequencer_if.sv
// Control/data bundle between the switch logic in top and the message sequencer.
// master drives the controls and write data; slave is the sequencer.
interface seg7_msg_sequencer_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CODE_W = 6
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic              clear;
  logic              play;
  logic              wr_en;
  logic [CODE_W-1:0] wr_data;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic [LEN_W-1:0]  len;
  logic              full;
  logic              playing;

  modport master (
    output clear, play, wr_en, wr_data,
    input  code_out, code_valid, len, full, playing
  );

  modport slave (
    input  clear, play, wr_en, wr_data,
    output code_out, code_valid, len, full, playing
  );
endinterface

// File: rtl/seg7_msg_sequencer.sv
// Stores a short message of display codes and loops it on one 7-segment digit,
// showing each character for HOLD_TICKS cycles followed by GAP_TICKS blank cycles.
module seg7_msg_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CODE_W     = 6,
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  seg7_msg_sequencer_if.slave   bus
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned LEN_W  = IDX_W + 1;
  localparam int unsigned MAX_T  = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int unsigned TICK_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = (GAP_TICKS > 0) ? TICK_W'(GAP_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TICK_W-1:0] tick_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [CODE_W-1:0] mem_q [DEPTH];

  logic              full;
  logic              wr_accept;
  logic [IDX_W-1:0]  idx_wrap;

  always_comb begin
    full      = (len_q == LEN_W'(DEPTH));
    wr_accept = (state_q == IDLE) && !bus.clear && !bus.play && bus.wr_en && !full;
    idx_wrap  = ({1'b0, idx_q} == len_q - 1'b1) ? '0 : idx_q + 1'b1;
  end

  // Buffer contents are don't-care after reset; only len_q marks what is valid.
  always_ff @(posedge clk_2) begin
    if (wr_accept) begin
      mem_q[len_q[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.clear) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        len_q <= len_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.play && (len_q != '0)) begin
            state_q <= SHOW;
            idx_q   <= '0;
            tick_q  <= '0;
            code_q  <= mem_q[0];
            valid_q <= 1'b1;
          end
        end
        SHOW: begin
          if (!bus.play) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            valid_q <= 1'b0;
          end else if (tick_q == HOLD_LAST) begin
            tick_q <= '0;
            // With no gap configured, chain straight into the next character.
            if (GAP_TICKS > 0) begin
              state_q <= GAP;
              valid_q <= 1'b0;
            end else begin
              idx_q  <= idx_wrap;
              code_q <= mem_q[idx_wrap];
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        GAP: begin
          if (!bus.play) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tick_q  <= '0;
            valid_q <= 1'b0;
          end else if (tick_q == GAP_LAST) begin
            state_q <= SHOW;
            tick_q  <= '0;
            idx_q   <= idx_wrap;
            code_q  <= mem_q[idx_wrap];
            valid_q <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.len        = len_q;
  assign bus.full       = full;
  assign bus.playing    = (state_q != IDLE);
endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Directed bench for seg7_msg_sequencer: one instance with a blank gap, one without.
module tb_seg7_msg_sequencer;
  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  seg7_msg_sequencer_if #(.DEPTH(8), .CODE_W(6)) ifa ();
  seg7_msg_sequencer_if #(.DEPTH(8), .CODE_W(6)) ifb ();

  seg7_msg_sequencer #(.DEPTH(8), .CODE_W(6), .HOLD_TICKS(2), .GAP_TICKS(1)) dut_a (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  seg7_msg_sequencer #(.DEPTH(8), .CODE_W(6), .HOLD_TICKS(2), .GAP_TICKS(0)) dut_b (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  int seq_code [10] = '{16, 16, 16, 17, 17, 17, 18, 18, 18, 16};
  int seq_v    [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  int seq_b    [5]  = '{9, 9, 10, 10, 9};

  initial begin
    ifa.clear = 1'b0; ifa.play = 1'b0; ifa.wr_en = 1'b0; ifa.wr_data = '0;
    ifb.clear = 1'b0; ifb.play = 1'b0; ifb.wr_en = 1'b0; ifb.wr_data = '0;

    // Reset state
    step(2);
    check("rst_valid", int'(ifa.code_valid), 0);
    check("rst_code", int'(ifa.code_out), 0);
    check("rst_len", int'(ifa.len), 0);
    check("rst_full", int'(ifa.full), 0);
    check("rst_playing", int'(ifa.playing), 0);
    reset_n = 1'b1;
    step(1);

    // Load A,b,C into A; code 9 into B
    ifa.wr_en = 1'b1;
    ifb.wr_en = 1'b1; ifb.wr_data = 6'd9;
    for (int i = 0; i < 3; i++) begin
      ifa.wr_data = 6'(16 + i);
      step(1);
      ifb.wr_en = 1'b0;
    end
    ifa.wr_en = 1'b0;
    check("load_len", int'(ifa.len), 3);
    check("load_full", int'(ifa.full), 0);
    check("load_valid", int'(ifa.code_valid), 0);
    check("load_len_b", int'(ifb.len), 1);

    // Playback with writes held high; every write must be dropped
    ifa.play = 1'b1; ifa.wr_en = 1'b1; ifa.wr_data = 6'd33;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("play_v%0d", i), int'(ifa.code_valid), seq_v[i]);
      check($sformatf("play_c%0d", i), int'(ifa.code_out), seq_code[i]);
    end
    check("play_playing", int'(ifa.playing), 1);
    step(2);
    check("pre_drop_gap", int'(ifa.code_valid), 0);
    ifa.play = 1'b0; ifa.wr_en = 1'b0;
    step(1);
    check("drop_gap_valid", int'(ifa.code_valid), 0);
    check("drop_gap_playing", int'(ifa.playing), 0);
    check("drop_len", int'(ifa.len), 3);

    // Restart must begin at index 0 and advance normally
    ifa.play = 1'b1;
    step(1);
    check("restart_c0", int'(ifa.code_out), 16);
    check("restart_v0", int'(ifa.code_valid), 1);
    step(3);
    check("restart_c1", int'(ifa.code_out), 17);
    ifa.play = 1'b0;
    step(1);

    // clear beats a simultaneous write
    ifa.clear = 1'b1; ifa.wr_en = 1'b1; ifa.wr_data = 6'd5;
    step(1);
    ifa.clear = 1'b0; ifa.wr_en = 1'b0;
    check("clear_len", int'(ifa.len), 0);
    check("clear_full", int'(ifa.full), 0);

    // play with empty buffer stays idle; play beats a same-cycle write
    ifa.play = 1'b1; ifa.wr_en = 1'b1; ifa.wr_data = 6'd7;
    step(2);
    check("empty_playing", int'(ifa.playing), 0);
    check("empty_valid", int'(ifa.code_valid), 0);
    check("empty_len", int'(ifa.len), 0);
    ifa.play = 1'b0; ifa.wr_en = 1'b0;
    step(1);

    // Fill to DEPTH, then a dropped 9th write
    ifa.wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.wr_data = 6'(20 + i);
      step(1);
    end
    check("fill_len", int'(ifa.len), 8);
    check("fill_full", int'(ifa.full), 1);
    ifa.wr_data = 6'd5;
    step(1);
    ifa.wr_en = 1'b0;
    check("over_len", int'(ifa.len), 8);
    check("over_full", int'(ifa.full), 1);

    ifa.play = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("full_c%0d", i), int'(ifa.code_out), 20 + i);
      check($sformatf("full_v%0d", i), int'(ifa.code_valid), 1);
      step(1);
      check($sformatf("full_h%0d", i), int'(ifa.code_out), 20 + i);
      step(1);
      check($sformatf("full_g%0d", i), int'(ifa.code_valid), 0);
    end
    step(1);
    check("full_wrap", int'(ifa.code_out), 20);
    ifa.play = 1'b0;
    step(1);
    ifa.clear = 1'b1; ifa.wr_en = 1'b1; ifa.wr_data = 6'd5;
    step(1);
    ifa.clear = 1'b0; ifa.wr_en = 1'b0;
    check("clear2_len", int'(ifa.len), 0);
    check("clear2_full", int'(ifa.full), 0);

    // No gap, single character: shown continuously
    ifb.play = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("nogap_c%0d", i), int'(ifb.code_out), 9);
      check($sformatf("nogap_v%0d", i), int'(ifb.code_valid), 1);
    end
    ifb.play = 1'b0;
    step(1);
    check("nogap_stop", int'(ifb.code_valid), 0);
    ifb.wr_en = 1'b1; ifb.wr_data = 6'd10;
    step(1);
    ifb.wr_en = 1'b0;
    check("nogap_len2", int'(ifb.len), 2);
    ifb.play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("nogap2_c%0d", i), int'(ifb.code_out), seq_b[i]);
      check($sformatf("nogap2_v%0d", i), int'(ifb.code_valid), 1);
    end

    // Asynchronous reset in the middle of SHOW
    ifa.wr_en = 1'b1; ifa.wr_data = 6'd30;
    step(1);
    ifa.wr_data = 6'd31;
    step(1);
    ifa.wr_en = 1'b0; ifa.play = 1'b1;
    step(1);
    check("pre_rst_valid", int'(ifa.code_valid), 1);
    check("pre_rst_code", int'(ifa.code_out), 30);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", int'(ifa.code_valid), 0);
    check("arst_playing", int'(ifa.playing), 0);
    check("arst_len", int'(ifa.len), 0);
    check("arst_valid_b", int'(ifb.code_valid), 0);
    check("arst_len_b", int'(ifb.len), 0);
    step(1);
    reset_n = 1'b1;
    step(2);
    check("post_rst_playing", int'(ifa.playing), 0);
    check("post_rst_valid", int'(ifa.code_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
